// File: rtl/mul_op_sequencer.sv
// mul_op_sequencer: streams stored operand pairs through an external clocked multiplier and stores the products
module mul_op_sequencer #(
  parameter int ADDR_W = 3,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_a,
  input  logic [3:0]        wr_b,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_z,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, WAIT, STORE, DONE} state_t;
  state_t state, next;
  logic [3:0] op_a [DEPTH];
  logic [3:0] op_b [DEPTH];
  logic [7:0] res [DEPTH];
  logic [ADDR_W:0] n, cnt_clamp;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [3:0] lat_cnt;
  logic last, accept;
  assign cnt_clamp = count > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : count;
  assign idx_nx = idx + ADDR_W'(1);
  assign last = (ADDR_W+1)'(idx) + (ADDR_W+1)'(1) == n;
  assign accept = state == IDLE && start && cnt_clamp != '0;
  always_comb begin
    next = state;
    next = state == IDLE  ? (start ? (cnt_clamp == '0 ? DONE : WAIT) : IDLE)
         : state == WAIT  ? (lat_cnt == 4'd1 ? STORE : WAIT)
         : state == STORE ? (last ? DONE : WAIT)
         : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      rd_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      lat_cnt <= '0;
      n <= '0;
    end else begin
      state <= next;
      done <= next == DONE;
      rd_data <= res[rd_addr];
      if (accept) begin
        n <= cnt_clamp;
        idx <= '0;
        mul_a <= op_a[0];
        mul_b <= op_b[0];
        lat_cnt <= 4'(MUL_LAT);
        busy <= 1'b1;
      end
      if (state == WAIT && lat_cnt != 4'd1) lat_cnt <= lat_cnt - 4'd1;
      if (state == STORE && !last) begin
        idx <= idx_nx;
        mul_a <= op_a[idx_nx];
        mul_b <= op_b[idx_nx];
        lat_cnt <= 4'(MUL_LAT);
      end
      if (next == DONE) busy <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      op_a[wr_addr] <= wr_a;
      op_b[wr_addr] <= wr_b;
    end
    if (state == STORE) res[idx] <= mul_z;
  end
endmodule

// File: tb/tb_mul_op_sequencer.sv
// tb_mul_op_sequencer: randomized and directed checks of mul_op_sequencer against a behavioural batch model
module tb_mul_op_sequencer;
  logic clk = 0, rst = 0, wr_en = 0, start = 0;
  logic [2:0] wr_addr = 0, rd_addr = 0;
  logic [3:0] wr_a = 0, wr_b = 0, count = 0;
  logic [3:0] a1, b1, a3, b3;
  logic [7:0] z1, z3, rd1, rd3;
  logic [7:0] zq [3];
  logic busy1, done1, busy3, done3;
  int checks = 0, errors = 0;
  int bcnt1 = 0, dcnt1 = 0, bcnt3 = 0, dcnt3 = 0;
  int opa [8], opb [8], res1 [8];
  always #5 clk = ~clk;
  mul_op_sequencer #(.ADDR_W(3), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .count(count), .mul_a(a1), .mul_b(b1), .mul_z(z1),
    .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .done(done1));
  mul_op_sequencer #(.ADDR_W(3), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .count(count), .mul_a(a3), .mul_b(b3), .mul_z(z3),
    .rd_addr(rd_addr), .rd_data(rd3), .busy(busy3), .done(done3));
  always @(posedge clk) begin
    z1 <= 8'(a1) * 8'(b1);
    zq[0] <= 8'(a3) * 8'(b3);
    zq[1] <= zq[0];
    zq[2] <= zq[1];
  end
  assign z3 = zq[2];
  always @(negedge clk) begin
    if (busy1) bcnt1++;
    if (done1) dcnt1++;
    if (busy3) bcnt3++;
    if (done3) dcnt3++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input int addr, input int a, input int b);
    wr_en = 1; wr_addr = 3'(addr); wr_a = 4'(a); wr_b = 4'(b);
    tick;
    wr_en = 0;
    opa[addr] = a;
    opb[addr] = b;
  endtask
  task automatic rd_chk(input string tag, input int addr, input bit s3, input int exp);
    rd_addr = 3'(addr);
    tick;
    check(tag, s3 ? int'(rd3) : int'(rd1), exp);
  endtask
  task automatic run(input int cnt, input bit s3);
    int n, t, lat, b0, d0;
    n = cnt > 8 ? 8 : cnt;
    lat = s3 ? 3 : 1;
    b0 = s3 ? bcnt3 : bcnt1;
    d0 = s3 ? dcnt3 : dcnt1;
    start = 1; count = 4'(cnt);
    tick;
    start = 0;
    t = 0;
    while (!(s3 ? done3 : done1) && t < 200) begin
      tick;
      t++;
    end
    check("batch_time", t, n * (lat + 1));
    tick;
    check("busy_cycles", (s3 ? bcnt3 : bcnt1) - b0, n * (lat + 1));
    check("done_pulses", (s3 ? dcnt3 : dcnt1) - d0, 1);
    if (!s3) for (int i = 0; i < n; i++) res1[i] = opa[i] * opb[i];
  endtask
  initial begin
    int b0, d0, t;
    rst = 1;
    tick;
    check("rst_mul_a", a1, 0);
    check("rst_mul_b", b1, 0);
    check("rst_rd_data", rd1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    rst = 0;
    tick;
    wr(0, 2, 2); wr(1, 3, 2); wr(2, 3, 6); wr(3, 5, 2); wr(4, 7, 1);
    run(5, 0);
    rd_chk("basic0", 0, 0, 8'h04);
    rd_chk("basic1", 1, 0, 8'h06);
    rd_chk("basic2", 2, 0, 8'h12);
    rd_chk("basic3", 3, 0, 8'h0A);
    rd_chk("basic4", 4, 0, 8'h07);
    d0 = dcnt1;
    start = 1; count = 5;
    tick;
    start = 0;
    repeat (3) tick;
    wr_en = 1; wr_addr = 1; wr_a = 1; wr_b = 1; start = 1;
    tick;
    wr_en = 0; start = 0;
    t = 0;
    while (!done1 && t < 200) begin tick; t++; end
    repeat (4) tick;
    check("busy_done_pulses", dcnt1 - d0, 1);
    rd_chk("busy_res1", 1, 0, 8'h06);
    run(5, 0);
    rd_chk("locked_res1", 1, 0, 8'h06);
    run(0, 0);
    for (int i = 0; i < 5; i++) rd_chk("cnt0_unchanged", i, 0, res1[i]);
    for (int i = 0; i < 8; i++) wr(i, 15, 15);
    run(9, 0);
    for (int i = 0; i < 8; i++) rd_chk("full_e1", i, 0, 8'hE1);
    wr(0, 9, 9); wr(1, 8, 3); wr(2, 4, 4); wr(3, 1, 2); wr(4, 2, 7);
    start = 1; count = 5;
    tick;
    start = 0;
    repeat (4) tick;
    rst = 1;
    tick;
    rst = 0;
    check("abort_mul_a", a1, 0);
    check("abort_mul_b", b1, 0);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    rd_chk("abort_res0", 0, 0, 8'h51);
    rd_chk("abort_res1", 1, 0, 8'h18);
    rd_chk("abort_res2", 2, 0, 8'hE1);
    rd_chk("abort_res4", 4, 0, 8'hE1);
    run(5, 0);
    for (int i = 0; i < 5; i++) rd_chk("rerun", i, 0, res1[i]);
    repeat (6) begin
      for (int i = 0; i < 8; i++) wr(i, int'($urandom_range(15)), int'($urandom_range(15)));
      run(int'($urandom_range(9)), 0);
      for (int i = 0; i < 8; i++) rd_chk("rand_res", i, 0, res1[i]);
    end
    rst = 1;
    tick;
    rst = 0;
    tick;
    wr(0, 3, 6); wr(1, 5, 7);
    run(1, 1);
    check("lat_hold_a", a3, 3);
    check("lat_hold_b", b3, 6);
    rd_chk("lat_res0", 0, 1, 8'h12);
    run(2, 1);
    rd_chk("lat2_res0", 0, 1, 8'h12);
    rd_chk("lat2_res1", 1, 1, 8'h23);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_op_sequencer.md
Name: mul_op_sequencer

Overview:
- Batch front/back-end for the clocked 4-bit multiplier `mul4c`.
- Holds up to DEPTH operand pairs in an internal operand RAM and streams them one pair at a time onto the multiplier's a/b inputs.
- Waits the multiplier latency, then captures each 8-bit product into an internal result RAM.
- The result RAM is readable by the surrounding RAM/datapath logic.

Parameters:
- ADDR_W, 3, address width of both RAMs; DEPTH = 2^ADDR_W entries (default 8).
- MUL_LAT, 1, number of clock edges after operands are presented before mul_z is valid (mul4c registers its output once); legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write operand pair into operand RAM (honoured only when busy=0)
- wr_addr  input  ADDR_W  operand RAM write address
- wr_a  input  4  operand A to store
- wr_b  input  4  operand B to store
- start  input  1  begin a batch (sampled only in IDLE)
- count  input  ADDR_W+1  number of pairs in the batch, sampled with start
- mul_a  output  4  registered operand A to mul4c
- mul_b  output  4  registered operand B to mul4c
- mul_z  input  8  product from mul4c
- rd_addr  input  ADDR_W  result RAM read address
- rd_data  output  8  registered result RAM read data, 1-cycle latency
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  one-cycle pulse at batch end

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE.
  - mul_a, mul_b, rd_data, busy and done are all cleared to 0.
  - The index and latency counters are cleared.
  - RAM contents are NOT cleared.
  - Reset mid-batch aborts immediately; results already written stay intact.
- FSM states: IDLE, WAIT, STORE, DONE.
- IDLE:
  - On start=1 with n>0, where n = min(count, DEPTH):
    - latch n;
    - set idx=0;
    - load mul_a/mul_b from opRAM[0];
    - set lat_cnt=MUL_LAT;
    - set busy=1;
    - go to WAIT.
  - On start=1 with count=0: go directly to DONE; no RAM writes; busy stays 0.
- WAIT:
  - Decrement lat_cnt each edge.
  - When lat_cnt reaches 1, go to STORE on that edge.
- STORE (one cycle):
  - Write mul_z into resRAM[idx].
  - If idx == n-1: go to DONE.
  - Otherwise, on the same edge:
    - idx = idx+1;
    - load mul_a/mul_b from opRAM[idx+1];
    - lat_cnt = MUL_LAT;
    - go to WAIT.
- Timing rule:
  - Operands presented at edge k are captured from mul_z at edge k+MUL_LAT+1.
  - Throughput is one pair per MUL_LAT+1 cycles.
  - Total batch time from the start-accept edge to the DONE entry edge is n*(MUL_LAT+1).
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- mul_a/mul_b hold their last values after a batch; they are cleared only by reset.
- Ignored inputs:
  - start while busy or in DONE is ignored.
  - wr_en while busy=1 is ignored, so the operand RAM is locked during a batch.
- Simultaneous events:
  - wr_en and start in the same IDLE cycle: the write is performed; the batch reads opRAM[0] via pre-write contents (read-before-write).
  - rd_addr equal to the resRAM address being written in the same cycle: rd_data returns the old value.
- Width rules:
  - Products are stored unmodified at 8 bits.
  - count values above DEPTH are clamped to DEPTH.
  - idx never wraps inside a batch.

Test Plan:
- **Basic batch:** load pairs (2,2),(3,2),(3,6),(5,2),(7,1) at addresses 0..4, pulse start with count=5, MUL_LAT=1 → busy for 10 cycles, done pulses once; reading addresses 0..4 returns 0x04, 0x06, 0x12, 0x0A, 0x07.
- **Full depth with extremes:** load all 8 entries with (15,15), then pulse start with count=9 → clamped to 8; every result is 0xE1; done occurs 16 cycles after start.
- **count=0:** pulse start with count=0 → done pulses on the next cycle, busy is never asserted, result RAM is unchanged.
- **Writes and start while busy:** mid-batch, drive wr_en to addr 1 with (1,1) and re-pulse start → neither has any effect; result[1] = 0x06 and exactly one done pulse occurs.
- **Reset mid-batch:** assert rst during WAIT of pair 2 → next cycle mul_a = mul_b = 0, busy = 0, done = 0; results 0 and 1 are retained; a new start reruns correctly from pair 0.
- **Latency parameter:** with MUL_LAT=3, run pair (3,6) → mul_z is sampled exactly 4 edges after operands appear; result = 0x12; batch of 2 pairs takes 8 cycles.
